// File: rtl/jtframe_db15_scan_if.sv
// DB15/SNAC scanner bundle: adapter pins plus host-side
// player select, button words and scan status.
interface jtframe_db15_scan_if #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12
);
  localparam int NPW = $clog2(PLAYERS+1);

  logic [NPW-1:0]          nplayers;
  logic                    joy_data;
  logic                    joy_clk;
  logic                    joy_load;
  logic [PLAYERS*BITS-1:0] joy_out;
  logic                    scan_done;
  logic                    active;

  modport master (
    input  nplayers, joy_data,
    output joy_clk, joy_load, joy_out,
    output scan_done, active
  );

  modport slave (
    output nplayers, joy_data,
    input  joy_clk, joy_load, joy_out,
    input  scan_done, active
  );
endinterface

// File: rtl/jtframe_db15_scan.sv
// Serial reader for the DB15/SNAC 74HC165 chain with an
// optional two-scan consistency filter on the button words.
module jtframe_db15_scan #(
  parameter int PLAYERS  = 2,
  parameter int BITS     = 12,
  parameter int CLKDIV   = 8,
  parameter int SCAN_GAP = 1024,
  parameter int FILTER   = 1
)(
  input  logic clk_sys,
  input  logic RESET,
  jtframe_db15_scan_if.master bus_io
);
  localparam int W    = PLAYERS*BITS;
  localparam int NPW  = $clog2(PLAYERS+1);
  localparam int NW   = $clog2(W+1);
  localparam int CMAX = CLKDIV > SCAN_GAP ? CLKDIV : SCAN_GAP;
  localparam int CW   = $clog2(CMAX+1);
  localparam bit LATE = CLKDIV < 3;
  localparam logic [CW-1:0] DIV_END = CW'(CLKDIV-1);
  localparam logic [CW-1:0] GAP_END = CW'(SCAN_GAP-1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHLO, SHHI, COMMIT, GAP
  } state_t;

  state_t         st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NW-1:0]  k_q, k_d;
  logic [NW-1:0]  n_q, n_d;
  logic [W-1:0]   raw_q, raw_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [W-1:0]   out_q, out_d;
  logic [1:0]     sync_q;
  logic           clk_q, clk_d;
  logic           load_q, load_d;
  logic           done_q, done_d;
  logic           act_q;
  logic [NPW-1:0] npc;
  logic [NW-1:0]  n_new;
  logic [W-1:0]   m_cur, m_new;
  logic           phase_end;
  logic           start;

  function automatic logic [W-1:0] mask_of(
    input logic [NW-1:0] n
  );
    logic [W-1:0] m;
    for (int i = 0; i < W; i++)
      m[i] = NW'(i) < n;
    return m;
  endfunction

  assign npc = (bus_io.nplayers > NPW'(PLAYERS))
             ? NPW'(PLAYERS) : bus_io.nplayers;
  assign n_new     = NW'(npc) * NW'(BITS);
  assign m_cur     = mask_of(n_q);
  assign m_new     = mask_of(n_new);
  assign phase_end = cnt_q == DIV_END;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    k_d    = k_q;
    n_d    = n_q;
    raw_d  = raw_q;
    prev_d = prev_q;
    out_d  = out_q;
    start  = 1'b0;
    unique case (st_q)
      IDLE: begin
        cnt_d = '0;
        start = npc != '0;
      end
      LOAD: if (phase_end) begin
        cnt_d = '0;
        k_d   = '0;
        st_d  = SHLO;
      end
      SHLO: if (phase_end) begin
        cnt_d = '0;
        st_d  = SHHI;
        if (!LATE) raw_d[k_q] = sync_q[1];
      end
      SHHI: if (phase_end) begin
        cnt_d = '0;
        if (LATE) raw_d[k_q] = sync_q[1];
        if (k_q == n_q - 1'b1) begin
          st_d = COMMIT;
        end else begin
          k_d  = k_q + 1'b1;
          st_d = SHLO;
        end
      end
      COMMIT: begin
        cnt_d  = '0;
        st_d   = GAP;
        prev_d = raw_q;
        if (FILTER == 0 ||
            (raw_q & m_cur) == (prev_q & m_cur))
          out_d = ~raw_q & m_cur;
      end
      GAP: if (cnt_q == GAP_END) begin
        cnt_d = '0;
        start = npc != '0;
      end
      default: st_d = IDLE;
    endcase
    // New geometry: drop stale players and force two fresh scans
    if (start) begin
      st_d  = LOAD;
      cnt_d = '0;
      n_d   = n_new;
      out_d = out_d & m_new;
      if (n_new != n_q) prev_d = '1;
    end
    if (npc == '0) begin
      st_d  = IDLE;
      cnt_d = '0;
      out_d = '0;
    end
  end

  always_comb begin
    clk_d  = !(st_d inside {LOAD, SHLO});
    load_d = st_d != LOAD;
    done_d = st_d == COMMIT;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      k_q    <= '0;
      n_q    <= '0;
      raw_q  <= '1;
      prev_q <= '1;
      out_q  <= '0;
      sync_q <= 2'b11;
      clk_q  <= 1'b1;
      load_q <= 1'b1;
      done_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      n_q    <= n_d;
      raw_q  <= raw_d;
      prev_q <= prev_d;
      out_q  <= out_d;
      sync_q <= {sync_q[0], bus_io.joy_data};
      clk_q  <= clk_d;
      load_q <= load_d;
      done_q <= done_d;
      act_q  <= npc != '0;
    end
  end

  assign bus_io.joy_clk   = clk_q;
  assign bus_io.joy_load  = load_q;
  assign bus_io.joy_out   = out_q;
  assign bus_io.scan_done = done_q;
  assign bus_io.active    = act_q;
endmodule

// File: tb/tb_jtframe_db15_scan.sv
// Bench for jtframe_db15_scan: 74HC165 chain model, per-scan
// vector table with an expected-result queue, plus corner cases.
module tb_jtframe_db15_scan;
  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;

  jtframe_db15_scan_if #(.PLAYERS(2), .BITS(12)) bus();

  jtframe_db15_scan #(
    .PLAYERS(2), .BITS(12), .CLKDIV(4),
    .SCAN_GAP(16), .FILTER(1)
  ) u_dut (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .bus_io (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // adapter: player 0 register sits next to the data pin
  logic [11:0] pat0 = '0, pat1 = '0;
  logic [23:0] sr = '1;
  logic pclk = 1'b1;
  always @(posedge clk_sys) begin
    pclk <= bus.joy_clk;
    if (!bus.joy_load)
      sr <= ~{pat1, pat0};
    else if (bus.joy_clk && !pclk)
      sr <= {1'b1, sr[23:1]};
  end
  assign bus.joy_data = sr[0];

  int cyc = 0, rises = 0, load_cyc = 0;
  logic pc = 1'b1, pl = 1'b1;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) begin
    if (bus.joy_clk && !pc) rises <= rises + 1;
    if (!bus.joy_load && pl) load_cyc <= cyc;
    pc <= bus.joy_clk;
    pl <= bus.joy_load;
  end

  typedef struct {
    logic [23:0] out;
    int          edges;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [1:0]  np;
    logic [11:0] p0;
    logic [11:0] p1;
    logic [23:0] out;
    int          edges;
  } vec_t;
  vec_t tbl[12];

  int n_vec = 0, n_bad = 0;
  int snap = 0, done_cyc = 0, prev_done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic run_scan(input logic [1:0] np,
                          input logic [11:0] a,
                          input logic [11:0] b,
                          input logic [23:0] eo,
                          input int ee);
    exp_t e;
    bit got = 0;
    bus.nplayers = np;
    pat0 = a;
    pat1 = b;
    q.push_back('{eo, ee});
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      if (bus.scan_done) got = 1;
    end
    e = q.pop_front();
    if (!got) begin
      chk("scan_timeout", 0, 1);
      return;
    end
    prev_done = done_cyc;
    done_cyc  = cyc;
    chk("edges", rises - snap, e.edges);
    snap = rises;
    @(negedge clk_sys);
    chk("joy_out", bus.joy_out, e.out);
    chk("done_pulse", bus.scan_done, 0);
    chk("active", bus.active, 1);
  endtask

  initial begin
    bit ok;
    int n;
    tbl[0]  = '{2'd1, 12'h008, 12'h000, 24'h000000, 12};
    tbl[1]  = '{2'd1, 12'h008, 12'h000, 24'h000008, 12};
    tbl[2]  = '{2'd2, 12'h005, 12'hA00, 24'h000008, 24};
    tbl[3]  = '{2'd2, 12'h005, 12'hA00, 24'hA00005, 24};
    tbl[4]  = '{2'd2, 12'h004, 12'hA00, 24'hA00005, 24};
    tbl[5]  = '{2'd2, 12'h005, 12'hA00, 24'hA00005, 24};
    tbl[6]  = '{2'd2, 12'h004, 12'hA00, 24'hA00005, 24};
    tbl[7]  = '{2'd2, 12'h004, 12'hA00, 24'hA00004, 24};
    tbl[8]  = '{2'd1, 12'h004, 12'hA00, 24'h000004, 12};
    tbl[9]  = '{2'd1, 12'h004, 12'hA00, 24'h000004, 12};
    tbl[10] = '{2'd3, 12'h004, 12'hA00, 24'h000004, 24};
    tbl[11] = '{2'd3, 12'h004, 12'hA00, 24'hA00004, 24};

    bus.nplayers = '0;
    repeat (3) @(negedge clk_sys);
    RESET = 1'b0;
    @(negedge clk_sys);
    chk("rst_clk",  bus.joy_clk, 1);
    chk("rst_load", bus.joy_load, 1);
    chk("rst_out",  bus.joy_out, 0);
    chk("rst_act",  bus.active, 0);
    chk("rst_done", bus.scan_done, 0);
    repeat (500) @(negedge clk_sys);
    chk("off_rises", rises, 0);
    snap = rises;

    for (int v = 0; v < 12; v++) begin
      run_scan(tbl[v].np, tbl[v].p0, tbl[v].p1,
               tbl[v].out, tbl[v].edges);
      if (v < 2) chk("scan_len", done_cyc - load_cyc, 100);
      if (v == 1) chk("period", done_cyc - prev_done, 117);
    end

    // abort during SHLO of bit 7
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_sys);
      ok = !bus.joy_load;
    end
    n = rises;
    ok = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(negedge clk_sys);
      ok = (rises - n == 7) && !bus.joy_clk;
    end
    chk("reach_bit7", ok, 1);
    #1 bus.nplayers = '0;
    @(negedge clk_sys);
    chk("abort_clk",  bus.joy_clk, 1);
    chk("abort_load", bus.joy_load, 1);
    chk("abort_out",  bus.joy_out, 0);
    chk("abort_act",  bus.active, 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.scan_done) n++;
      @(negedge clk_sys);
    end
    chk("abort_nodone", n, 0);
    #1 bus.nplayers = 2'd2;
    @(negedge clk_sys);
    chk("restart_load", bus.joy_load, 0);

    // asynchronous reset while in SHHI
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_sys);
      ok = bus.joy_clk;
    end
    chk("reach_shhi", ok, 1);
    #1 RESET = 1'b1;
    #1;
    chk("arst_clk",  bus.joy_clk, 1);
    chk("arst_load", bus.joy_load, 1);
    chk("arst_out",  bus.joy_out, 0);
    chk("arst_act",  bus.active, 0);
    pat0 = 12'h005;
    pat1 = 12'hA00;
    repeat (2) @(negedge clk_sys);
    RESET = 1'b0;
    snap = rises;
    run_scan(2'd2, 12'h005, 12'hA00, 24'h000000, 24);
    run_scan(2'd2, 12'h005, 12'hA00, 24'hA00005, 24);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/jtframe_db15_scan.md
Name: jtframe_db15_scan

Overview:
- Parametrised serial-joystick reader for the DB15/SNAC adapter on the MiSTer user port.
- Drives the adapter's parallel-load shift-register chain (JOY_LOAD/JOY_CLK), shifts JOY_DATA for 1..PLAYERS players and publishes debounced active-high button words.
- Successor to the fixed 2-player reader inside jtframe_mister: generalises player count, bits per player and timing, and adds a scan-consistency filter.
- Sits between the user-port pins and the joystick mux in the frame.

Parameters:
- PLAYERS, 2: maximum number of players in the chain.
- BITS, 12: bits per player.
- CLKDIV, 8: clk_sys cycles per JOY_CLK half-period and per load pulse; must be ≥1.
- SCAN_GAP, 1024: idle clk_sys cycles between scans; must be ≥1.
- FILTER, 1: 1 = commit only when two consecutive scans match; 0 = commit every scan.

Ports:
- clk_sys, in, 1: system clock.
- RESET, in, 1: asynchronous, active-high reset.
- nplayers, in, $clog2(PLAYERS+1): number of players to scan; 0 = off; values above PLAYERS clamp to PLAYERS.
- joy_data, in, 1: serial data from the adapter, active-low buttons; synchronised internally through 2 flops.
- joy_clk, out, 1: shift clock to the adapter.
- joy_load, out, 1: parallel load, active-low.
- joy_out, out, PLAYERS*BITS: active-high buttons; player p occupies bits [p*BITS +: BITS].
- scan_done, out, 1: one-cycle pulse at the end of every completed scan.
- active, out, 1: registered (nplayers != 0); drives USER_MODE and the pin-ownership mux.

Behaviour:
- Reset values: joy_clk=1, joy_load=1, joy_out=0, scan_done=0, active=0. FSM resets to IDLE; previous-scan buffer resets to all ones.
- States: IDLE, LOAD, SHLO, SHHI, COMMIT, GAP.
- IDLE: outputs idle-high. If the clamped nplayers is non-zero, latch it as np, set N = np*BITS and go to LOAD.
- LOAD: joy_load=0 and joy_clk=0 for CLKDIV cycles, then go to SHLO with bit index k=0.
- SHLO: joy_load=1, joy_clk=0 for CLKDIV cycles.
  - On the last cycle, sample the synchronised joy_data into raw[k].
  - The 2-flop synchroniser delay is absorbed by the phase length; implementation must guarantee ≥2 settle cycles before sampling when CLKDIV<3 (sample at end of the next SHHI instead).
- SHHI: joy_clk=1 for CLKDIV cycles.
  - If k == N-1, go to COMMIT.
  - Otherwise k++ and go to SHLO.
- COMMIT (1 cycle): scan_done=1.
  - If FILTER==0, or raw[N-1:0] equals the previous raw[N-1:0], set joy_out[N-1:0] = ~raw[N-1:0] and clear joy_out bits ≥N.
  - Store raw as the previous scan. Go to GAP.
- GAP: SCAN_GAP cycles with joy_clk=1, joy_load=1.
  - At the end, re-evaluate nplayers: 0 → IDLE; else re-latch np and go to LOAD.
- Scan length, LOAD entry to COMMIT: CLKDIV + N*2*CLKDIV cycles. Period = that + 1 + SCAN_GAP.
- nplayers changes:
  - Non-zero changes take effect only at the GAP→LOAD boundary.
  - A change that alters N invalidates the previous buffer (set to all ones), so the filter needs two fresh scans.
  - nplayers going to 0 in any state aborts the scan: on the next cycle the FSM is in IDLE, joy_clk=1, joy_load=1, joy_out=0, active=0, and there is no scan_done pulse.
- active follows nplayers!=0 with 1-cycle latency.
- RESET mid-scan: immediate return to reset values; no partial commit.
- joy_out bits for players ≥ np are always 0.

Test Plan (PLAYERS=2, BITS=12, CLKDIV=4, SCAN_GAP=16, FILTER=1; adapter model = chained 74HC165):
- Reset with nplayers=0 → joy_clk=1, joy_load=1, joy_out=0, active=0, and no joy_clk edges for 500 cycles.
- nplayers=1, model holds all ones except bit 3 low → first scan_done leaves joy_out=0; second scan_done sets joy_out=24'h000008; LOAD-to-COMMIT = 100 cycles, period = 117 cycles.
- nplayers=2, P1 pattern 12'h005 pressed, P2 12'hA00 pressed → after 2 scans joy_out=24'hA00005; 24 joy_clk rising edges per scan.
- Stable 24'hA00005, then one scan with P1 bit 0 flipped → joy_out unchanged and scan_done still pulses; flip held for two scans → joy_out=24'hA00004.
- nplayers 2→0 during SHLO of bit 7 → next cycle joy_clk=1, joy_load=1, joy_out=0, active=0, no scan_done; restoring nplayers=2 restarts at LOAD.
- RESET asserted asynchronously mid-SHHI → outputs take reset values within the same cycle; after release, 2 full scans are needed before joy_out is non-zero.
